// File: rtl/lpgbt_cmd_scheduler.sv
// Round-robin scheduler for the shared 160-bit IC/GBT-SCA command path.
// Admits one transaction at a time. After each FIFO write it waits for a
// downstream completion or a timeout, then inserts a guard gap before the
// next grant.
module lpgbt_cmd_scheduler #(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int GAP_CYCLES     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [160*NUM_REQ-1:0] req_command,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [159:0]           cmd_fifo_din,
  output logic                   cmd_fifo_wr,
  input  logic                   cmd_fifo_full,
  input  logic                   txn_done,
  output logic [2:0]             grant_id,
  output logic                   busy,
  output logic                   timeout_pulse,
  output logic [15:0]            timeout_count,
  output logic [15:0]            drop_count
);

  localparam int unsigned NREQ       = NUM_REQ;
  localparam logic [15:0] TIMER_LOAD = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  GAP_LOAD   = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
  localparam logic [2:0]  PTR_RST    = 3'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_WAIT_DONE,
    ST_GAP
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    grant_q, grant_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [159:0]  din_q, din_d;
  logic [15:0]   timer_q, timer_d;
  logic [7:0]    gap_q, gap_d;
  logic [15:0]   tcnt_q, tcnt_d;
  logic [15:0]   dcnt_q, dcnt_d;

  logic          arb_found;
  logic [2:0]    arb_idx;
  logic [159:0]  arb_cmd;
  logic          sel_valid;
  logic          cmd_typed;
  logic          ready_pulse;

  // Round-robin search starting one past the pointer; also muxes the winner's command.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_cmd   = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!arb_found && req_valid[j] && (((32'(ptr_q) + i) % NREQ) == j)) begin
          arb_found = 1'b1;
          arb_idx   = 3'(j);
          arb_cmd   = req_command[j*160 +: 160];
        end
      end
    end
  end

  // Valid of the currently granted requester, and whether the captured command carries a type bit.
  always_comb begin
    sel_valid = 1'b0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (3'(j) == grant_q) sel_valid = req_valid[j];
    end
    cmd_typed = din_q[159] | din_q[79] | din_q[41] | din_q[40];
  end

  // Next-state and combinational strobes of the scheduler FSM.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    ptr_d         = ptr_q;
    din_d         = din_q;
    timer_d       = timer_q;
    gap_d         = gap_q;
    tcnt_d        = tcnt_q;
    dcnt_d        = dcnt_q;
    cmd_fifo_wr   = 1'b0;
    ready_pulse   = 1'b0;
    timeout_pulse = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          grant_d = arb_idx;
          din_d   = arb_cmd;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!sel_valid) begin
          state_d = ST_IDLE;
        end else if (!cmd_typed) begin
          ready_pulse = 1'b1;
          if (dcnt_q != 16'hFFFF) dcnt_d = dcnt_q + 16'd1;
          ptr_d   = grant_q;
          state_d = ST_IDLE;
        end else if (!cmd_fifo_full) begin
          cmd_fifo_wr = 1'b1;
          ready_pulse = 1'b1;
          ptr_d       = grant_q;
          timer_d     = TIMER_LOAD;
          state_d     = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (txn_done || (timer_q == '0)) begin
          if (!txn_done) begin
            timeout_pulse = 1'b1;
            if (tcnt_q != 16'hFFFF) tcnt_d = tcnt_q + 16'd1;
          end
          gap_d   = GAP_LOAD;
          state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Accept pulse goes only to the granted requester.
  always_comb begin
    req_ready = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      req_ready[j] = ready_pulse && (3'(j) == grant_q);
    end
  end

  // State and datapath registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= PTR_RST;
      ptr_q   <= PTR_RST;
      din_q   <= '0;
      timer_q <= '0;
      gap_q   <= '0;
      tcnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      din_q   <= din_d;
      timer_q <= timer_d;
      gap_q   <= gap_d;
      tcnt_q  <= tcnt_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign cmd_fifo_din  = din_q;
  assign grant_id      = grant_q;
  assign busy          = (state_q != ST_IDLE);
  assign timeout_count = tcnt_q;
  assign drop_count    = dcnt_q;

endmodule

// File: tb/tb_lpgbt_cmd_scheduler.sv
// Self-checking bench for lpgbt_cmd_scheduler: scoreboard of expected
// FIFO writes plus directed timing checks.
module tb_lpgbt_cmd_scheduler;

  localparam int NREQ = 3;
  localparam int TOUT = 16;
  localparam int GAP  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NREQ-1:0]  req_valid;
  logic [159:0]     cmd [NREQ];
  logic [160*NREQ-1:0] req_command;
  logic [NREQ-1:0]  req_ready;
  logic [159:0]     cmd_fifo_din;
  logic             cmd_fifo_wr;
  logic             cmd_fifo_full;
  logic             txn_done;
  logic [2:0]       grant_id;
  logic             busy;
  logic             timeout_pulse;
  logic [15:0]      timeout_count;
  logic [15:0]      drop_count;

  assign req_command = {cmd[2], cmd[1], cmd[0]};

  lpgbt_cmd_scheduler #(
    .NUM_REQ       (NREQ),
    .TIMEOUT_CYCLES(TOUT),
    .GAP_CYCLES    (GAP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_command  (req_command),
    .req_ready    (req_ready),
    .cmd_fifo_din (cmd_fifo_din),
    .cmd_fifo_wr  (cmd_fifo_wr),
    .cmd_fifo_full(cmd_fifo_full),
    .txn_done     (txn_done),
    .grant_id     (grant_id),
    .busy         (busy),
    .timeout_pulse(timeout_pulse),
    .timeout_count(timeout_count),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   id;
    logic [159:0] cmd;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   wr_count = 0;
  int   ready_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] mkcmd(input int bitpos, input logic [31:0] tag);
    logic [159:0] c;
    c = '0;
    c[31:0]   = tag;
    c[119:88] = $urandom();
    if (bitpos >= 0) c[bitpos] = 1'b1;
    return c;
  endfunction

  task automatic push(input int id);
    exp_t e;
    e.id  = 3'(id);
    e.cmd = cmd[id];
    exp_q.push_back(e);
  endtask

  // Scoreboard: every FIFO write must match the next expected (id, command).
  always @(negedge clk) begin
    if (rst_n) begin
      if (|req_ready) ready_count++;
      if (cmd_fifo_wr) begin
        wr_count++;
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_wr", 1, 0);
        end else begin
          exp_t e;
          logic [2:0] oh;
          e  = exp_q.pop_front();
          oh = 3'(1 << e.id);
          chk("sb_id", grant_id, e.id);
          chk("sb_din", cmd_fifo_din, e.cmd);
          chk("sb_ready", req_ready, oh);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_wr();
    bit got = 0;
    int n = 0;
    while (!got && n < 60) begin
      @(negedge clk);
      got = cmd_fifo_wr;
      n++;
    end
    if (!got) chk("wr_wait_expired", 0, 1);
  endtask

  task automatic wait_idle();
    bit idle = 0;
    int n = 0;
    while (!idle && n < 60) begin
      @(negedge clk);
      idle = !busy;
      n++;
    end
    if (!idle) chk("idle_wait_expired", 0, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_din"}, cmd_fifo_din, 0);
    chk({tag, "_wr"}, cmd_fifo_wr, 0);
    chk({tag, "_grant"}, grant_id, 2);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_tpulse"}, timeout_pulse, 0);
    chk({tag, "_tcount"}, timeout_count, 0);
    chk({tag, "_dcount"}, drop_count, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic serve(input int id);
    wait_wr();
    chk("serve_id", grant_id, id);
    tick();
    req_valid[id] = 1'b0;
    txn_done = 1'b1;
    tick();
    txn_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int wr0, r0, c0, prev_id, prev_cyc, g;
    rst_n = 1'b0;
    req_valid = '0;
    cmd_fifo_full = 1'b0;
    txn_done = 1'b0;
    for (int i = 0; i < NREQ; i++) cmd[i] = '0;

    // Reset values
    @(negedge clk);
    check_reset_vals("rst");
    tick();
    rst_n = 1'b1;

    // Single request from requester 1, done 5 cycles after the write
    wr0 = wr_count;
    r0  = ready_count;
    cmd[1] = mkcmd(41, 32'h0000_0101);
    push(1);
    req_valid = 3'b010;
    wait_wr();
    c0 = cyc;
    chk("single_ready", req_ready, 3'b010);
    chk("single_grant", grant_id, 1);
    tick();
    req_valid = '0;
    repeat (4) tick();
    txn_done = 1'b1;
    tick();
    txn_done = 1'b0;
    repeat (4) @(negedge clk);
    chk("single_busy_gap_end", busy, 1);
    chk("single_gap_cycle", cyc - c0, 9);
    @(negedge clk);
    chk("single_idle", busy, 0);
    chk("single_wr_count", wr_count - wr0, 1);
    chk("single_ready_count", ready_count - r0, 1);

    // Fairness with all requesters continuously valid and prompt completion
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      cmd[i] = mkcmd(159, 32'(100 + i));
      push(i);
    end
    req_valid = 3'b111;
    prev_id = 7;
    prev_cyc = 0;
    for (int k = 0; k < 6; k++) begin
      wait_wr();
      g = k % NREQ;
      chk("rr_order", grant_id, g);
      if (k > 0) begin
        chk("rr_repeat", (grant_id == 3'(prev_id)), 0);
        chk("rr_spacing", cyc - prev_cyc, 3 + GAP);
      end
      prev_id = int'(grant_id);
      prev_cyc = cyc;
      tick();
      if (k < 3) begin
        cmd[g] = mkcmd(159, 32'(200 + g));
        push(g);
      end else begin
        req_valid[g] = 1'b0;
      end
      txn_done = 1'b1;
      tick();
      txn_done = 1'b0;
    end
    wait_idle();

    // Back-pressure: FIFO full for 10 cycles in GRANT
    cmd_fifo_full = 1'b1;
    cmd[2] = mkcmd(79, 32'h0000_0302);
    push(2);
    req_valid = 3'b100;
    tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_no_wr", cmd_fifo_wr, 0);
      chk("bp_no_ready", req_ready, 0);
      tick();
    end
    cmd_fifo_full = 1'b0;
    @(negedge clk);
    chk("bp_wr", cmd_fifo_wr, 1);
    chk("bp_ready", req_ready, 3'b100);
    tick();
    req_valid = '0;
    txn_done = 1'b1;
    tick();
    txn_done = 1'b0;
    wait_idle();

    // Timeout with no completion, then a stray txn_done during the gap
    wr0 = wr_count;
    cmd[0] = mkcmd(79, 32'h0000_0400);
    push(0);
    req_valid = 3'b001;
    wait_wr();
    chk("to_grant", grant_id, 0);
    tick();
    req_valid = '0;
    for (int i = 1; i <= TOUT; i++) begin
      @(negedge clk);
      chk("to_pulse", timeout_pulse, (i == TOUT));
    end
    tick();
    txn_done = 1'b1;
    @(negedge clk);
    chk("to_count", timeout_count, 1);
    tick();
    txn_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("to_gap_busy", busy, 1);
    @(negedge clk);
    chk("to_gap_idle", busy, 0);
    chk("to_wr_count", wr_count - wr0, 1);

    // Untyped command is dropped; pointer moves past the dropped requester
    wr0 = wr_count;
    cmd[1] = mkcmd(-1, 32'h0000_1234);
    req_valid = 3'b010;
    begin
      bit got = 0;
      int n = 0;
      while (!got && n < 20) begin
        @(negedge clk);
        got = |req_ready;
        n++;
      end
      if (!got) chk("drop_wait_expired", 0, 1);
    end
    chk("drop_ready", req_ready, 3'b010);
    chk("drop_no_wr", cmd_fifo_wr, 0);
    tick();
    cmd[1] = mkcmd(40, 32'h0000_0501);
    cmd[2] = mkcmd(159, 32'h0000_0502);
    push(2);
    push(1);
    req_valid = 3'b110;
    @(negedge clk);
    chk("drop_count", drop_count, 1);
    chk("drop_wr_count", wr_count - wr0, 0);
    serve(2);
    serve(1);
    wait_idle();

    // Reset asserted in WAIT_DONE
    cmd[0] = mkcmd(41, 32'h0000_0600);
    push(0);
    req_valid = 3'b001;
    wait_wr();
    tick();
    rst_n = 1'b0;
    req_valid = '0;
    @(negedge clk);
    check_reset_vals("rst_wait");
    tick();
    rst_n = 1'b1;
    cmd[0] = mkcmd(159, 32'h0000_0700);
    cmd[1] = mkcmd(79, 32'h0000_0701);
    push(0);
    push(1);
    req_valid = 3'b011;
    serve(0);
    serve(1);
    wait_idle();

    chk("sb_leftover", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
